// File: rtl/execute_alu_fwd_pkg.sv
// -----------------------------------------------------------------------------
// execute_alu_fwd_pkg
//   Shared definitions for the execute stage: forwarding select codes, the
//   aluOp encodings carried in calculationControl[2:1], and the R-type funct
//   opcodes decoded when aluOp selects the funct field.
// -----------------------------------------------------------------------------
package execute_alu_fwd_pkg;

  // Operand source chosen by the forwarding unit. Code 2'b11 never occurs.
  typedef enum logic [1:0] {
    NOMINAL = 2'b00,  // register-file value from ID/EX
    MEMWB   = 2'b01,  // MEM/WB write-back data
    EXMEM   = 2'b10   // EX/MEM registered ALU result
  } fwd_sel_e;

  // ALU operation class from the main decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // R-type funct opcodes (immediateOperand[5:0]).
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/execute_alu_fwd_if.sv
// -----------------------------------------------------------------------------
// execute_alu_fwd_if
//   Bundles the ID/EX inputs, the MEM/WB forwarding inputs and the EX/MEM
//   outputs of the execute stage. Clock and reset stay outside the bundle.
//   slave  : the execute stage (consumes ID/EX + MEM/WB, drives EX/MEM).
//   master : whoever drives the stage (pipeline or testbench).
// -----------------------------------------------------------------------------
interface execute_alu_fwd_if #(
  parameter int WIDTH = 32
);
  // ID/EX side
  logic [1:0]       writeBackControlIn;   // bit1 = RegWrite
  logic [1:0]       memAccessControlIn;   // passed through unchanged
  logic [3:0]       calculationControl;   // [3]=regDst [2:1]=aluOp [0]=aluSrc
  logic [WIDTH-1:0] readData1;            // rs value
  logic [WIDTH-1:0] readData2;            // rt value
  logic [WIDTH-1:0] immediateOperand;     // sign-extended imm, [5:0] = funct
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rdIn;
  // MEM/WB forwarding source
  logic             memWbRegWrite;
  logic [4:0]       memWbRd;
  logic [WIDTH-1:0] memWbData;
  // EX/MEM side (registered)
  logic [1:0]       writeBackControlOut;
  logic [1:0]       memAccessControlOut;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] writeData;
  logic [4:0]       rdOut;

  modport slave (
    input  writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    output writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );

  modport master (
    output writeBackControlIn, memAccessControlIn, calculationControl,
           readData1, readData2, immediateOperand, rs, rt, rdIn,
           memWbRegWrite, memWbRd, memWbData,
    input  writeBackControlOut, memAccessControlOut, result, writeData, rdOut
  );

endinterface

// File: rtl/execute_alu_fwd_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU. Arithmetic wraps; no overflow detection.
//   i_operand1 / i_operand2 : operands (shift amount is i_operand2[4:0])
//   i_alu_op                : operation class from the decoder
//   i_funct                 : R-type funct, used only for ALUOP_FUNCT
//   o_result                : ALU output (0 for an unknown funct)
// -----------------------------------------------------------------------------
module alu_core
  import execute_alu_fwd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_operand1,
  input  logic [WIDTH-1:0] i_operand2,
  input  alu_op_e          i_alu_op,
  input  logic [5:0]       i_funct,
  output logic [WIDTH-1:0] o_result
);

  logic [4:0] w_shamt;
  logic       w_lt_signed;
  logic       w_lt_unsigned;

  assign w_shamt       = i_operand2[4:0];
  assign w_lt_signed   = $signed(i_operand1) < $signed(i_operand2);
  assign w_lt_unsigned = i_operand1 < i_operand2;

  // NOTE: assign a default before the case so every path drives o_result;
  // otherwise an unlisted funct would infer a latch.
  always_comb begin
    o_result = '0;
    case (i_alu_op)
      ALUOP_ADD: o_result = i_operand1 + i_operand2;
      ALUOP_SUB: o_result = i_operand1 - i_operand2;
      ALUOP_OR:  o_result = i_operand1 | i_operand2;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD, FUNCT_ADDU: o_result = i_operand1 + i_operand2;
          FUNCT_SUB, FUNCT_SUBU: o_result = i_operand1 - i_operand2;
          FUNCT_AND:  o_result = i_operand1 & i_operand2;
          FUNCT_OR:   o_result = i_operand1 | i_operand2;
          FUNCT_XOR:  o_result = i_operand1 ^ i_operand2;
          FUNCT_NOR:  o_result = ~(i_operand1 | i_operand2);
          FUNCT_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
          FUNCT_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
          FUNCT_SLL:  o_result = i_operand1 << w_shamt;
          FUNCT_SRL:  o_result = i_operand1 >> w_shamt;
          FUNCT_SRA:  o_result = $signed(i_operand1) >>> w_shamt;
          default:    o_result = '0;
        endcase
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_alu_fwd_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Forwarding unit: picks the source of each ALU operand.
//   i_exmem_reg_write / i_exmem_rd : RegWrite and rd held in EX/MEM
//   i_memwb_reg_write / i_memwb_rd : RegWrite and rd held in MEM/WB
//   i_rs / i_rt                    : source registers of the instruction in EX
//   o_sel1 / o_sel2                : select codes for rs / rt
//   The younger EX/MEM value wins over MEM/WB; register 0 is never forwarded.
// -----------------------------------------------------------------------------
module fwd_select
  import execute_alu_fwd_pkg::*;
(
  input  logic     i_exmem_reg_write,
  input  logic [4:0] i_exmem_rd,
  input  logic     i_memwb_reg_write,
  input  logic [4:0] i_memwb_rd,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output fwd_sel_e o_sel1,
  output fwd_sel_e o_sel2
);

  function automatic fwd_sel_e select_for(
    input logic [4:0] src,
    input logic       exmem_we,
    input logic [4:0] exmem_rd,
    input logic       memwb_we,
    input logic [4:0] memwb_rd
  );
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src))
      return EXMEM;
    else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == src))
      return MEMWB;
    else
      return NOMINAL;
  endfunction

  assign o_sel1 = select_for(i_rs, i_exmem_reg_write, i_exmem_rd,
                             i_memwb_reg_write, i_memwb_rd);
  assign o_sel2 = select_for(i_rt, i_exmem_reg_write, i_exmem_rd,
                             i_memwb_reg_write, i_memwb_rd);

endmodule

// File: rtl/execute_alu_fwd.sv
// -----------------------------------------------------------------------------
// execute_alu_fwd
//   EX stage of the 5-stage pipeline: forwarding unit, operand muxes, ALU and
//   the EX/MEM pipeline register. All state updates on the falling clock edge.
//   clk   : stage clock (falling edge active)
//   reset : synchronous, active-high; clears every EX/MEM output
//   bus   : ID/EX inputs, MEM/WB forwarding inputs, EX/MEM outputs
// -----------------------------------------------------------------------------
module execute_alu_fwd
  import execute_alu_fwd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  execute_alu_fwd_if.slave   bus
);

  // EX/MEM register
  logic [1:0]       r_wb_ctrl;
  logic [1:0]       r_mem_ctrl;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_write_data;
  logic [4:0]       r_rd;

  fwd_sel_e         w_sel1;
  fwd_sel_e         w_sel2;
  logic [WIDTH-1:0] w_operand1;
  logic [WIDTH-1:0] w_fwd2;
  logic [WIDTH-1:0] w_operand2;
  logic [WIDTH-1:0] w_alu_result;
  logic [4:0]       w_rd_next;
  alu_op_e          w_alu_op;

  // The EX/MEM side of forwarding is this stage's own registered output.
  fwd_select u_fwd_select (
    .i_exmem_reg_write (r_wb_ctrl[1]),
    .i_exmem_rd        (r_rd),
    .i_memwb_reg_write (bus.memWbRegWrite),
    .i_memwb_rd        (bus.memWbRd),
    .i_rs              (bus.rs),
    .i_rt              (bus.rt),
    .o_sel1            (w_sel1),
    .o_sel2            (w_sel2)
  );

  always_comb begin
    w_operand1 = bus.readData1;
    case (w_sel1)
      EXMEM:   w_operand1 = r_result;
      MEMWB:   w_operand1 = bus.memWbData;
      default: w_operand1 = bus.readData1;
    endcase
  end

  always_comb begin
    w_fwd2 = bus.readData2;
    case (w_sel2)
      EXMEM:   w_fwd2 = r_result;
      MEMWB:   w_fwd2 = bus.memWbData;
      default: w_fwd2 = bus.readData2;
    endcase
  end

  assign w_operand2 = bus.calculationControl[0] ? bus.immediateOperand : w_fwd2;
  assign w_alu_op   = alu_op_e'(bus.calculationControl[2:1]);
  assign w_rd_next  = bus.calculationControl[3] ? bus.rdIn : bus.rt;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .i_operand1 (w_operand1),
    .i_operand2 (w_operand2),
    .i_alu_op   (w_alu_op),
    .i_funct    (bus.immediateOperand[5:0]),
    .o_result   (w_alu_result)
  );

  // NOTE: non-blocking assignments here so every EX/MEM field samples the
  // pre-edge values, including r_result which also feeds the operand muxes.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_wb_ctrl    <= '0;
      r_mem_ctrl   <= '0;
      r_result     <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
    end else begin
      r_wb_ctrl    <= bus.writeBackControlIn;
      r_mem_ctrl   <= bus.memAccessControlIn;
      r_result     <= w_alu_result;
      r_write_data <= w_fwd2;  // store data ignores aluSrc
      r_rd         <= w_rd_next;
    end
  end

  assign bus.writeBackControlOut = r_wb_ctrl;
  assign bus.memAccessControlOut = r_mem_ctrl;
  assign bus.result              = r_result;
  assign bus.writeData           = r_write_data;
  assign bus.rdOut               = r_rd;

endmodule

// File: tb/tb_execute_alu_fwd.sv
// -----------------------------------------------------------------------------
// tb_execute_alu_fwd
//   Drives the execute stage with directed and random instructions and
//   compares every EX/MEM output against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_execute_alu_fwd;

  logic clk = 1'b0;
  logic reset;

  execute_alu_fwd_if #(.WIDTH(32)) bus ();

  execute_alu_fwd #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [3:0]  cc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rdin;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
  } stim_t;

  int checks   = 0;
  int failures = 0;

  // Model of the EX/MEM register contents.
  logic [1:0]  m_wb;
  logic [1:0]  m_mem;
  logic [31:0] m_result;
  logic [31:0] m_wdata;
  logic [4:0]  m_rd;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [5:0] funct);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: begin
        case (funct)
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          // signed compare via sign-bit flip into unsigned space
          6'h2A: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          6'h00: return a << sh;
          6'h02: return a >> sh;
          6'h03: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] source_value(input logic [4:0] src, input logic [31:0] rf,
                                               input stim_t s);
    if (src != 5'd0 && m_wb[1] && m_rd == src) return m_result;
    if (src != 5'd0 && s.mwb_we && s.mwb_rd == src) return s.mwb_data;
    return rf;
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s.wb = 2'b00; s.mem = 2'b01; s.cc = 4'b0100;
    s.rd1 = '0; s.rd2 = '0; s.imm = '0;
    s.rs = 5'd0; s.rt = 5'd0; s.rdin = 5'd0;
    s.mwb_we = 1'b0; s.mwb_rd = 5'd0; s.mwb_data = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [5:0] codes [14];
    codes = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
              6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
    s.wb       = 2'($urandom_range(0, 3));
    s.mem      = 2'($urandom_range(0, 3));
    s.cc       = 4'($urandom_range(0, 15));
    s.rd1      = $urandom();
    s.rd2      = $urandom();
    s.imm      = $urandom();
    if ($urandom_range(0, 9) != 0) s.imm[5:0] = codes[$urandom_range(0, 13)];
    s.rs       = 5'($urandom_range(0, 3));   // narrow range => frequent hazards
    s.rt       = 5'($urandom_range(0, 3));
    s.rdin     = 5'($urandom_range(0, 3));
    s.mwb_we   = 1'($urandom_range(0, 1));
    s.mwb_rd   = 5'($urandom_range(0, 3));
    s.mwb_data = $urandom();
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.writeBackControlIn = s.wb;
    bus.memAccessControlIn = s.mem;
    bus.calculationControl = s.cc;
    bus.readData1          = s.rd1;
    bus.readData2          = s.rd2;
    bus.immediateOperand   = s.imm;
    bus.rs                 = s.rs;
    bus.rt                 = s.rt;
    bus.rdIn               = s.rdin;
    bus.memWbRegWrite      = s.mwb_we;
    bus.memWbRd            = s.mwb_rd;
    bus.memWbData          = s.mwb_data;
  endtask

  // One instruction through EX: predict, clock one falling edge, compare.
  task automatic apply(input stim_t s, input string tag);
    logic [31:0] op1, fwd2, op2, e_res;
    logic [4:0]  e_rd;
    op1   = source_value(s.rs, s.rd1, s);
    fwd2  = source_value(s.rt, s.rd2, s);
    op2   = s.cc[0] ? s.imm : fwd2;
    e_res = ref_alu(op1, op2, s.cc[2:1], s.imm[5:0]);
    e_rd  = s.cc[3] ? s.rdin : s.rt;
    reset = 1'b0;
    drive(s);
    @(negedge clk); #1;
    checks += 5;
    if (bus.writeBackControlOut !== s.wb) begin
      failures++; $display("FAIL %s.wb got=%b exp=%b", tag, bus.writeBackControlOut, s.wb);
    end
    if (bus.memAccessControlOut !== s.mem) begin
      failures++; $display("FAIL %s.mem got=%b exp=%b", tag, bus.memAccessControlOut, s.mem);
    end
    if (bus.result !== e_res) begin
      failures++; $display("FAIL %s.result got=%h exp=%h", tag, bus.result, e_res);
    end
    if (bus.writeData !== fwd2) begin
      failures++; $display("FAIL %s.writeData got=%h exp=%h", tag, bus.writeData, fwd2);
    end
    if (bus.rdOut !== e_rd) begin
      failures++; $display("FAIL %s.rdOut got=%0d exp=%0d", tag, bus.rdOut, e_rd);
    end
    m_wb = s.wb; m_mem = s.mem; m_result = e_res; m_wdata = fwd2; m_rd = e_rd;
  endtask

  // Reset edge with random live inputs: reset must override them.
  task automatic do_reset(input string tag);
    drive(rand_stim());
    reset = 1'b1;
    @(negedge clk); #1;
    checks += 5;
    if (bus.writeBackControlOut !== 2'b00) begin
      failures++; $display("FAIL %s.wb got=%b exp=00", tag, bus.writeBackControlOut);
    end
    if (bus.memAccessControlOut !== 2'b00) begin
      failures++; $display("FAIL %s.mem got=%b exp=00", tag, bus.memAccessControlOut);
    end
    if (bus.result !== 32'd0) begin
      failures++; $display("FAIL %s.result got=%h exp=0", tag, bus.result);
    end
    if (bus.writeData !== 32'd0) begin
      failures++; $display("FAIL %s.writeData got=%h exp=0", tag, bus.writeData);
    end
    if (bus.rdOut !== 5'd0) begin
      failures++; $display("FAIL %s.rdOut got=%0d exp=0", tag, bus.rdOut);
    end
    reset = 1'b0;
    m_wb = '0; m_mem = '0; m_result = '0; m_wdata = '0; m_rd = '0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_basic_add();
    stim_t s;
    s = blank();
    s.wb = 2'b10; s.imm = 32'h20; s.rd1 = 32'd5; s.rd2 = 32'd7;
    s.rs = 5'd1; s.rt = 5'd2; s.rdin = 5'd9;
    apply(s, "basic_add");
    checks += 3;
    if (bus.result !== 32'd12) begin
      failures++; $display("FAIL basic_add.plan_result got=%h exp=0000000c", bus.result);
    end
    if (bus.writeData !== 32'd7) begin
      failures++; $display("FAIL basic_add.plan_writeData got=%h exp=00000007", bus.writeData);
    end
    if (bus.rdOut !== 5'd2) begin
      failures++; $display("FAIL basic_add.plan_rdOut got=%0d exp=2", bus.rdOut);
    end
  endtask

  // Producer writing rd=3 with result 0x10 (rs/rt chosen hazard-free).
  function automatic stim_t producer_rd3();
    stim_t s;
    s = blank();
    s.wb = 2'b10; s.cc = 4'b1000; s.rd1 = 32'h10; s.rd2 = 32'h0;
    s.rs = 5'd4; s.rt = 5'd5; s.rdin = 5'd3;
    return s;
  endfunction

  task automatic test_exmem_forward();
    stim_t s;
    apply(producer_rd3(), "exmem_producer");
    s = blank();
    s.imm = 32'h22; s.rs = 5'd3; s.rt = 5'd5; s.rd1 = 32'd0; s.rd2 = 32'd4;
    apply(s, "exmem_fwd");
    checks++;
    if (bus.result !== 32'h0C) begin
      failures++; $display("FAIL exmem_fwd.plan_result got=%h exp=0000000c", bus.result);
    end
  endtask

  task automatic test_priority();
    stim_t s;
    apply(producer_rd3(), "prio_producer");
    s = blank();
    s.imm = 32'h25; s.rs = 5'd0; s.rt = 5'd3; s.rd1 = 32'd0; s.rd2 = 32'h77;
    s.mwb_we = 1'b1; s.mwb_rd = 5'd3; s.mwb_data = 32'h99;
    apply(s, "priority");
    checks += 2;
    if (bus.result !== 32'h10) begin
      failures++; $display("FAIL priority.plan_result got=%h exp=00000010", bus.result);
    end
    if (bus.writeData !== 32'h10) begin
      failures++; $display("FAIL priority.plan_writeData got=%h exp=00000010", bus.writeData);
    end
  endtask

  task automatic test_reg0_guard();
    stim_t s;
    // Producer targets r0 with RegWrite set: must not be forwarded either.
    s = blank();
    s.wb = 2'b10; s.cc = 4'b1000; s.rd1 = 32'h55; s.rs = 5'd6; s.rt = 5'd6; s.rdin = 5'd0;
    apply(s, "reg0_producer");
    s = blank();
    s.imm = 32'h20; s.rs = 5'd0; s.rt = 5'd7; s.rd1 = 32'd0; s.rd2 = 32'd1;
    s.mwb_we = 1'b1; s.mwb_rd = 5'd0; s.mwb_data = 32'hFF;
    apply(s, "reg0_guard");
    checks++;
    if (bus.result !== 32'd1) begin
      failures++; $display("FAIL reg0_guard.plan_result got=%h exp=00000001", bus.result);
    end
  endtask

  task automatic test_immediate();
    stim_t s;
    s = blank();
    s.cc = 4'b0001; s.imm = 32'hFFFF_FFFC; s.rd1 = 32'd8; s.rd2 = 32'h55;
    s.rs = 5'd8; s.rt = 5'd9; s.rdin = 5'd12;
    apply(s, "immediate");
    checks += 3;
    if (bus.result !== 32'd4) begin
      failures++; $display("FAIL immediate.plan_result got=%h exp=00000004", bus.result);
    end
    if (bus.writeData !== 32'h55) begin
      failures++; $display("FAIL immediate.plan_writeData got=%h exp=00000055", bus.writeData);
    end
    if (bus.rdOut !== 5'd9) begin
      failures++; $display("FAIL immediate.plan_rdOut got=%0d exp=9", bus.rdOut);
    end
  endtask

  task automatic test_funct_edges();
    stim_t s;
    s = blank();
    s.rs = 5'd10; s.rt = 5'd11; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1;
    s.imm = 32'h2A;
    apply(s, "slt");
    checks++;
    if (bus.result !== 32'd1) begin
      failures++; $display("FAIL slt.plan_result got=%h exp=00000001", bus.result);
    end
    s.imm = 32'h2B;
    apply(s, "sltu");
    checks++;
    if (bus.result !== 32'd0) begin
      failures++; $display("FAIL sltu.plan_result got=%h exp=00000000", bus.result);
    end
    s.imm = 32'h03; s.rd1 = 32'h8000_0000; s.rd2 = 32'd4;
    apply(s, "sra");
    checks++;
    if (bus.result !== 32'hF800_0000) begin
      failures++; $display("FAIL sra.plan_result got=%h exp=f8000000", bus.result);
    end
    // Non-zero outputs in flight, then reset mid-stream.
    s.wb = 2'b11; s.mem = 2'b11; s.cc = 4'b1000; s.rdin = 5'd17;
    apply(s, "pre_reset");
    do_reset("mid_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset("rand_reset");
      else apply(rand_stim(), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(blank());
    test_reset();
    test_basic_add();
    test_exmem_forward();
    test_priority();
    test_reg0_guard();
    test_immediate();
    test_funct_edges();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_alu_fwd.md
Name: execute_alu_fwd

Overview:
- Execute (EX) stage of the 5-stage MIPS-style pipeline. Sits between the ID/EX and EX/MEM pipeline registers.
- A forwarding unit selects each ALU operand from three sources: the register file, the EX/MEM result, or the MEM/WB write-back data.
- The ALU computes a 32-bit result, which is registered into the EX/MEM register together with the pass-through control, store data and destination register.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required to work.

Ports:
- clk  in  1  stage clock; all registers update on the falling edge.
- reset  in  1  synchronous, active-high; sampled on the same falling edge.
- writeBackControlIn  in  2  WB control; bit1 = RegWrite.
- memAccessControlIn  in  2  MEM control, passed through unchanged.
- calculationControl  in  4  [3]=regDst, [2:1]=aluOp, [0]=aluSrc.
- readData1  in  32  rs value from the register file.
- readData2  in  32  rt value from the register file.
- immediateOperand  in  32  sign-extended immediate; [5:0] is the funct field.
- rs, rt, rdIn  in  5 each  register specifiers.
- memWbRegWrite  in  1  MEM/WB RegWrite.
- memWbRd  in  5  MEM/WB destination register.
- memWbData  in  32  MEM/WB write-back value.
- writeBackControlOut  out  2  registered copy of writeBackControlIn.
- memAccessControlOut  out  2  registered copy of memAccessControlIn.
- result  out  32  registered ALU result.
- writeData  out  32  registered forwarded rt value (store data).
- rdOut  out  5  registered destination register.

Behaviour:
- Forwarding, computed separately for rs (operand1) and rt (operand2):
  - Select code 10 (EX/MEM): writeBackControlOut[1]=1, rdOut!=0 and rdOut equals the source register.
  - Otherwise select code 01 (MEM/WB): memWbRegWrite=1, memWbRd!=0 and memWbRd equals the source register.
  - Otherwise select code 00: register-file value.
  - EX/MEM has priority when both stages match. Register 0 is never forwarded.
- Operand muxes:
  - operand1 = readData1, memWbData or result, per its select code.
  - fwd2 is chosen the same way from readData2, memWbData or result.
  - operand2 = immediateOperand when aluSrc=1, else fwd2.
- ALU is combinational. Operation by aluOp:
  - 00: add.
  - 01: subtract (operand1 - operand2).
  - 11: bitwise OR.
  - 10: decoded from funct = immediateOperand[5:0].
- Funct codes (used only when aluOp=10):
  - 0x20/0x21: add.
  - 0x22/0x23: sub.
  - 0x24: and.
  - 0x25: or.
  - 0x26: xor.
  - 0x27: nor.
  - 0x2A: slt (signed, result 1 or 0).
  - 0x2B: sltu.
  - 0x00: sll, operand1 << operand2[4:0].
  - 0x02: srl, logical right by operand2[4:0].
  - 0x03: sra, arithmetic right by operand2[4:0].
  - Any other funct: result 0.
- Arithmetic wraps modulo 2^32. No overflow trap or flag.
- Registered outputs, latency 1 falling edge:
  - writeBackControlOut <= writeBackControlIn.
  - memAccessControlOut <= memAccessControlIn.
  - result <= ALU output.
  - writeData <= fwd2. Always the forwarded rt value, even when aluSrc=1.
  - rdOut <= rdIn when regDst=1, else rt.
- Reset: on a falling edge with reset=1, all five outputs become 0 (reset overrides new data). Forwarding from EX/MEM is therefore inactive after reset.
- Select code 11 cannot occur. Operands are don't-care for that code.

Decomposition:
- Shared package holds:
  - forwarding select constants: NOMINAL=2'b00, MEMWB=2'b01, EXMEM=2'b10;
  - aluOp encodings;
  - funct opcode constants.
- Sub-modules: the ALU is its own sub-module, alu_core, purely combinational. The forwarding logic is a second natural sub-module, fwd_select. The top instantiates both plus the EX/MEM register.

Test Plan:
- Reset, then release. aluOp=10, funct=0x20, readData1=5, readData2=7, no hazards -> after one falling edge result=12, writeData=7, rdOut=rt (regDst=0).
- EX/MEM forward: previous instruction wrote rd=3 with result=0x10 and RegWrite=1. Next instruction has rs=3, readData1=0, funct=0x22, readData2=4 -> result=0x0C.
- Priority: EX/MEM rd=3 result=0x10 and MEM/WB rd=3 memWbData=0x99 both valid, rt=3, funct=0x25, operand1=0 -> result=0x10 and writeData=0x10.
- Register-0 guard: memWbRd=0, memWbRegWrite=1, memWbData=0xFF, rs=0, readData1=0, funct=0x20, readData2=1 -> result=1.
- Immediate path: aluSrc=1, aluOp=00, immediateOperand=0xFFFFFFFC, readData1=8, readData2=0x55, regDst=0 -> result=4, writeData=0x55.
- Funct coverage: slt with 0xFFFFFFFF vs 1 -> 1; sltu on the same values -> 0; sra of 0x80000000 by 4 -> 0xF8000000. Assert reset mid-stream -> all outputs 0 at that edge.
